// File: rtl/control_unit.sv
// control_unit -- hardwired fetch/decode/execute sequencer.
//
// Reads the opcode from the IR (i_ir_cu) and the ALU flags (i_flags) and drives
// the C0..C15 transfer strobes, the ALU opcode (C19..C16), MAR increment (C22),
// halt (C23) and the memory write strobe. Every output is decoded from the
// registered state and the opcode latched in DEC (op_q). The one exception is
// C3 in the E0 cycle of a conditional jump, which follows i_flags directly.
//
// Ports
//   i_clk                 system clock, rising edge
//   i_rst                 asynchronous active-high reset
//   i_cpu_start           level run enable, sampled in IDLE and at each
//                         instruction boundary
//   i_ir_cu[7:0]          opcode from IR, latched at the end of DEC
//   i_flags[4:0]          {parity, overflow, carry, negative, zero}
//   o_ctrl[15:0]          bit n = Cn strobe
//   o_alu_op[3:0]         [3] ALU enable, [2:0] ALU function
//   o_ctrl_mar_increment  C22, always 0 in this ISA revision
//   o_ctrl_halt           C23
//   o_mem_we              memory write strobe
//   o_busy                high outside IDLE and HALT
//   o_instr_done          one-cycle pulse in the last execute cycle
//   o_illegal             sticky unknown-opcode flag
//   o_state[3:0]          debug view of the sequencer state
//
// Configuration macro: CU_ILLEGAL_TRAP_EN
//   defined   : an unknown opcode sets o_illegal in E0 and enters HALT
//   undefined : an unknown opcode runs as NOP and o_illegal stays 0
//
// i_cpu_start is a plain level enable, not a valid/ready handshake. It is only
// looked at when the sequencer sits in IDLE or finishes an instruction, so
// dropping it in the middle of an instruction lets that instruction finish.
module control_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cpu_start,
  input  logic [7:0]  i_ir_cu,
  input  logic [4:0]  i_flags,
  output logic [15:0] o_ctrl,
  output logic [3:0]  o_alu_op,
  output logic        o_ctrl_mar_increment,
  output logic        o_ctrl_halt,
  output logic        o_mem_we,
  output logic        o_busy,
  output logic        o_instr_done,
  output logic        o_illegal,
  output logic [3:0]  o_state
);

`ifdef CU_ILLEGAL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_F0   = 4'd1,
    S_F1   = 4'd2,
    S_F2   = 4'd3,
    S_F3   = 4'd4,
    S_DEC  = 4'd5,
    S_E0   = 4'd6,
    S_E1   = 4'd7,
    S_E2   = 4'd8,
    S_E3   = 4'd9,
    S_HALT = 4'd10
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] op_q;
  logic       illegal_q;
  logic       last_cycle;

  // Carry, overflow and parity are produced by the register file but no
  // instruction in this ISA revision branches on them.
  logic unused_flags;
  assign unused_flags = &{1'b0, i_flags[4:2]};

  // Opcode classes, all decoded from the latched opcode.
  logic op_nop, op_store, op_load, op_jmp, op_jgez, op_jz, op_halt, op_alu;
  logic op_known;

  assign op_nop   = (op_q == 8'h00);
  assign op_store = (op_q == 8'h01);
  assign op_load  = (op_q == 8'h02);
  assign op_jmp   = (op_q == 8'h03);
  assign op_jgez  = (op_q == 8'h04);
  assign op_jz    = (op_q == 8'h06);
  assign op_halt  = (op_q == 8'h07);
  assign op_alu   = (op_q[7:3] == 5'b00001);
  assign op_known = op_nop | op_store | op_load | op_jmp | op_jgez | op_jz |
                    op_halt | op_alu;

  // State, opcode latch and sticky illegal flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      op_q      <= 8'h00;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DEC) begin
        op_q <= i_ir_cu;
      end
      if (TRAP_EN && state_q == S_E0 && !op_known) begin
        illegal_q <= 1'b1;
      end
    end
  end

  // Next state and Moore outputs.
  always_comb begin
    state_d      = state_q;
    o_ctrl       = 16'h0000;
    o_alu_op     = 4'h0;
    o_ctrl_halt  = 1'b0;
    o_mem_we     = 1'b0;
    o_instr_done = 1'b0;
    last_cycle   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_cpu_start) begin
          state_d = S_F0;
        end
      end
      S_F0: begin
        o_ctrl[2] = 1'b1;
        state_d   = S_F1;
      end
      S_F1: begin
        o_ctrl[0] = 1'b1;
        o_ctrl[5] = 1'b1;
        state_d   = S_F2;
      end
      S_F2: begin
        o_ctrl[4] = 1'b1;
        state_d   = S_F3;
      end
      S_F3: begin
        o_ctrl[15:14] = 2'b11;
        state_d       = S_DEC;
      end
      S_DEC: begin
        state_d = S_E0;
      end
      S_E0: begin
        if (op_store || op_load || op_alu) begin
          o_ctrl[8] = 1'b1;
          state_d   = S_E1;
        end else if (op_jmp) begin
          o_ctrl[3]  = 1'b1;
          last_cycle = 1'b1;
        end else if (op_jgez) begin
          // Taken when the last ALU result was not negative.
          o_ctrl[3]  = ~i_flags[1];
          last_cycle = 1'b1;
        end else if (op_jz) begin
          o_ctrl[3]  = i_flags[0];
          last_cycle = 1'b1;
        end else if (op_halt) begin
          o_instr_done = 1'b1;
          state_d      = S_HALT;
        end else if (!op_known && TRAP_EN) begin
          // Trapped opcode: straight to HALT without completing.
          state_d = S_HALT;
        end else begin
          // NOP, and unknown opcodes when trapping is disabled.
          last_cycle = 1'b1;
        end
      end
      S_E1: begin
        if (op_store) begin
          o_ctrl[12] = 1'b1;
        end else begin
          o_ctrl[0] = 1'b1;
          o_ctrl[5] = 1'b1;
        end
        state_d = S_E2;
      end
      S_E2: begin
        if (op_store) begin
          o_ctrl[0]  = 1'b1;
          o_ctrl[13] = 1'b1;
          o_mem_we   = 1'b1;
          last_cycle = 1'b1;
        end else if (op_load) begin
          o_ctrl[11] = 1'b1;
          last_cycle = 1'b1;
        end else if (op_alu) begin
          o_ctrl[7:6] = 2'b11;
          o_alu_op    = {1'b1, op_q[2:0]};
          state_d     = S_E3;
        end else begin
          last_cycle = 1'b1;
        end
      end
      S_E3: begin
        o_ctrl[9]  = 1'b1;
        // MPY writes the upper half of the product as well.
        o_ctrl[10] = (op_q[2:0] == 3'b111);
        last_cycle = 1'b1;
      end
      S_HALT: begin
        o_ctrl_halt = 1'b1;
      end
      default: begin
        // Unreachable encodings recover to IDLE.
        state_d = S_IDLE;
      end
    endcase

    if (last_cycle) begin
      o_instr_done = 1'b1;
      state_d      = i_cpu_start ? S_F0 : S_IDLE;
    end
  end

  assign o_ctrl_mar_increment = 1'b0;
  assign o_busy    = (state_q != S_IDLE) && (state_q != S_HALT);
  assign o_illegal = TRAP_EN ? illegal_q : 1'b0;
  assign o_state   = state_q;

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control sequencer that sits directly beside the register file top level. It consumes the opcode (`i_ir_cu`) and ALU flags (`i_flags`) produced by the register file. It generates the C0–C15 transfer strobes, the 4-bit ALU opcode (C19–C16), MAR increment (C22), halt (C23) and the memory write enable. Each instruction runs as a fixed fetch/decode/execute micro-sequence driven by a one-hot-safe encoded state register.

## Interface
- No parameters.
- `i_clk  input  1`: system clock, all state on rising edge.
- `i_rst  input  1`: asynchronous, active-high reset.
- `i_cpu_start  input  1`: level run enable, sampled in IDLE and at every instruction boundary.
- `i_ir_cu  input  8`: opcode from IR.
- `i_flags  input  5`: [0] zero, [1] negative, [2] carry, [3] overflow, [4] parity.
- `o_ctrl  output  16`: bit n = Cn strobe.
- `o_alu_op  output  4`: [3] ALU enable, [2:0] ALU function.
- `o_ctrl_mar_increment  output  1`: C22; held 0 in this ISA revision.
- `o_ctrl_halt  output  1`: C23.
- `o_mem_we  output  1`: memory write strobe.
- `o_busy  output  1`: high in any state except IDLE/HALT.
- `o_instr_done  output  1`: one-cycle pulse in the last execute cycle of each instruction.
- `o_illegal  output  1`: sticky unknown-opcode flag; see Configuration.

## Operation
- States: IDLE, F0, F1, F2, F3, DEC, E0–E3, HALT.
- All outputs are Moore-decoded from the registered state plus the latched opcode `op_q`. No output depends combinationally on `i_flags` except the C3 strobe in a conditional-jump E0.
- Fetch sequence:
  - F0: C2.
  - F1: C0, C5.
  - F2: C4.
  - F3: C14, C15.
  - DEC: no strobes; `op_q <= i_ir_cu` at the end of DEC; next state is E0.
- Execute sequences, listed as the strobes asserted in each cycle. The last listed cycle pulses `o_instr_done`, then goes to F0 if `i_cpu_start`=1, else IDLE.
  - 0x00 NOP: E0 none.
  - 0x01 STORE: E0 C8; E1 C12; E2 C0+C13+`o_mem_we`.
  - 0x02 LOAD: E0 C8; E1 C0+C5; E2 C11.
  - 0x03 JMP: E0 C3.
  - 0x04 JGEZ: E0 C3 only if `i_flags[1]`=0.
  - 0x06 JZ: E0 C3 only if `i_flags[0]`=1.
  - 0x07 HALT: E0 none; next state HALT.
  - 0x08–0x0F ALU ops (`o_alu_op[2:0]=op_q[2:0]`: ADD, SUB, AND, OR, NOT, SHL, SHR, MPY):
    - E0 C8.
    - E1 C0+C5.
    - E2 C6+C7+`o_alu_op[3]`.
    - E3 C9; for MPY, C10 is also asserted in E3.
- HALT: `o_ctrl_halt`=1 and all other strobes 0. HALT is left only by reset.
- IDLE: all outputs 0; goes to F0 on `i_cpu_start`=1.
- Opcodes 0x05 and 0x10–0xFF are unknown; their handling is set by the macro.

## Timing
- Reset value: state IDLE, `op_q`=0x00. `o_ctrl`, `o_alu_op`, `o_ctrl_halt`, `o_ctrl_mar_increment`, `o_mem_we`, `o_busy`, `o_instr_done` and `o_illegal` are all 0.
- Reset asserted mid-instruction forces IDLE and zero outputs immediately, without waiting for a clock edge.
- The first F0 follows one cycle after `i_cpu_start` is sampled high in IDLE.
- Instruction latency including fetch+DEC (5 cycles):
  - NOP/JMP/JGEZ/JZ/HALT: 6 cycles.
  - LOAD/STORE: 8 cycles.
  - ALU ops: 9 cycles.
- Deasserting `i_cpu_start` mid-instruction completes that instruction, then enters IDLE. Reasserting it resumes at F0 with no lost state.
- Flags are sampled only in JGEZ/JZ E0. The flags valid in that cycle reflect the last completed ALU instruction.
- `o_mem_we` is high for exactly one cycle, coincident with C0 and C13.

## Configuration
- Macro: `CU_ILLEGAL_TRAP_EN`.
- Defined: an unknown opcode in E0 sets `o_illegal`=1 (sticky until reset) and enters HALT; `o_instr_done` is not pulsed.
- Undefined: an unknown opcode executes as NOP (E0 none, `o_instr_done` pulsed). `o_illegal` is tied to 0.

## Test plan
- Reset with `i_cpu_start`=1, then release → F0 one cycle after release. The first five cycles show `o_ctrl` = 0x0004, 0x0021, 0x0010, 0xC000, 0x0000.
- Opcode 0x08 (ADD) → E0–E3 `o_ctrl` = 0x0100, 0x0021, 0x00C0 with `o_alu_op`=4'b1000, then 0x0200. `o_instr_done` pulses in E3; 9 cycles total.
- Opcode 0x01 (STORE) → E2 has `o_ctrl`=0x2001 and `o_mem_we`=1 for exactly one cycle.
- Opcode 0x04 (JGEZ):
  - with `i_flags`=5'b00010 → no C3;
  - with `i_flags`=5'b00000 → `o_ctrl`=0x0008 in E0.
- Opcode 0x07 (HALT) → `o_ctrl_halt`=1 held for 20+ cycles regardless of `i_cpu_start`. Asserting `i_rst` clears it asynchronously.
- Opcode 0x20:
  - with `CU_ILLEGAL_TRAP_EN` → `o_illegal`=1, `o_ctrl_halt`=1;
  - without it → NOP, `o_instr_done` pulse, next F0.
